// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: op codes, FSM states and
// pipeline/divider handshake levels.
package muldiv_ctrl_pkg;

   localparam int unsigned StallBusW = 6;
   localparam int unsigned StallEx   = 2;

   localparam logic [2:0] MulDivOpMult  = 3'b000;
   localparam logic [2:0] MulDivOpMultu = 3'b001;
   localparam logic [2:0] MulDivOpDiv   = 3'b010;
   localparam logic [2:0] MulDivOpDivu  = 3'b011;
   localparam logic [2:0] MulDivOpMthi  = 3'b100;
   localparam logic [2:0] MulDivOpMtlo  = 3'b101;

   localparam logic Stop           = 1'b1;
   localparam logic NoStop         = 1'b0;
   localparam logic DivStart       = 1'b1;
   localparam logic DivStop        = 1'b0;
   localparam logic DivResultReady = 1'b1;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   typedef enum logic [1:0] {
      StIdle,
      StMulBusy,
      StDivBusy,
      StDone
   } state_e;

   // mult/multu/div/divu all have op[2] clear; mthi/mtlo set it.
   function automatic logic is_arith_op(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg
   import muldiv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hi_we_i,
   input  logic [31:0] hi_wdata_i,
   input  logic        lo_we_i,
   input  logic [31:0] lo_wdata_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [31:0] hi_q;
   logic [31:0] lo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= ZeroWord;
         lo_q <= ZeroWord;
      end else begin
         if (hi_we_i) hi_q <= hi_wdata_i;
         if (lo_we_i) lo_q <= lo_wdata_i;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the iterative divider and pipelined multiplier; owns HI/LO and
// holds the pipeline until a multi-cycle result is committed.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 2,
   parameter int unsigned DIV_TIMEOUT = 40
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [StallBusW-1:0] stall,
   input  logic                 flush,
   input  logic                 op_valid,
   input  logic [2:0]           op,
   input  logic [31:0]          src1,
   input  logic [31:0]          src2,
   output logic [31:0]          hi_o,
   output logic [31:0]          lo_o,
   output logic                 stallreq_for_muldiv,
   output logic                 busy,
   output logic [31:0]          div_opdata1_o,
   output logic [31:0]          div_opdata2_o,
   output logic                 div_start_o,
   output logic                 signed_div_o,
   output logic                 div_annul_o,
   input  logic [63:0]          div_result_i,
   input  logic                 div_ready_i,
   output logic [31:0]          mul_ina,
   output logic [31:0]          mul_inb,
   output logic                 mul_signed_o,
   input  logic [63:0]          mul_result_i
);

   localparam int unsigned    ToW     = $clog2(DIV_TIMEOUT + 1);
   localparam logic [3:0]     MulLoad = 4'(MUL_LATENCY);
   localparam logic [ToW-1:0] ToLast  = ToW'(DIV_TIMEOUT - 1);

   state_e         state_q;
   logic [3:0]     mul_cnt_q;
   logic [ToW-1:0] to_cnt_q;
   logic [63:0]    res_q;
   logic [31:0]    mul_ina_q, mul_inb_q, div_op1_q, div_op2_q;
   logic           mul_signed_q, signed_div_q, div_start_q, div_annul_q;

   logic           is_idle, commit, hi_we, lo_we;
   logic [31:0]    hi_wdata, lo_wdata;
   logic           unused_stall;

   assign unused_stall = ^{stall[StallBusW-1:StallEx+1], stall[StallEx-1:0]};

   always_comb begin
      is_idle  = (state_q == StIdle);
      commit   = (state_q == StDone) && !flush && (stall[StallEx] == NoStop);
      hi_we    = commit || (is_idle && op_valid && !flush && (op == MulDivOpMthi));
      lo_we    = commit || (is_idle && op_valid && !flush && (op == MulDivOpMtlo));
      hi_wdata = commit ? res_q[63:32] : src1;
      lo_wdata = commit ? res_q[31:0]  : src1;
      stallreq_for_muldiv = !rst && ((is_idle && op_valid && is_arith_op(op)) ||
                                     (state_q == StMulBusy) || (state_q == StDivBusy));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         mul_cnt_q    <= '0;
         to_cnt_q     <= '0;
         res_q        <= '0;
         mul_ina_q    <= ZeroWord;
         mul_inb_q    <= ZeroWord;
         div_op1_q    <= ZeroWord;
         div_op2_q    <= ZeroWord;
         mul_signed_q <= 1'b0;
         signed_div_q <= 1'b0;
         div_start_q  <= DivStop;
         div_annul_q  <= 1'b0;
      end else if (flush) begin
         state_q      <= StIdle;
         res_q        <= '0;
         mul_ina_q    <= ZeroWord;
         mul_inb_q    <= ZeroWord;
         div_op1_q    <= ZeroWord;
         div_op2_q    <= ZeroWord;
         mul_signed_q <= 1'b0;
         signed_div_q <= 1'b0;
         div_start_q  <= DivStop;
         div_annul_q  <= (state_q == StDivBusy);
      end else begin
         div_annul_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (op_valid) begin
                  case (op)
                     MulDivOpMult, MulDivOpMultu: begin
                        mul_ina_q    <= src1;
                        mul_inb_q    <= src2;
                        mul_signed_q <= ~op[0];
                        mul_cnt_q    <= MulLoad;
                        state_q      <= StMulBusy;
                     end
                     MulDivOpDiv, MulDivOpDivu: begin
                        div_op1_q    <= src1;
                        div_op2_q    <= src2;
                        signed_div_q <= ~op[0];
                        div_start_q  <= DivStart;
                        to_cnt_q     <= '0;
                        state_q      <= StDivBusy;
                     end
                     default: ;
                  endcase
               end
            end
            StMulBusy: begin
               mul_cnt_q <= mul_cnt_q - 4'd1;
               if (mul_cnt_q == 4'd1) begin
                  res_q   <= mul_result_i;
                  state_q <= StDone;
               end
            end
            StDivBusy: begin
               if (div_ready_i == DivResultReady) begin
                  res_q       <= div_result_i;
                  div_start_q <= DivStop;
                  state_q     <= StDone;
               end else if (to_cnt_q == ToLast) begin
                  // Divider never answered: abandon without touching HI/LO.
                  div_annul_q  <= 1'b1;
                  div_start_q  <= DivStop;
                  div_op1_q    <= ZeroWord;
                  div_op2_q    <= ZeroWord;
                  signed_div_q <= 1'b0;
                  state_q      <= StIdle;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            StDone: begin
               // op_valid is deliberately ignored here so a held instruction is not re-run.
               if (stall[StallEx] == NoStop) begin
                  mul_ina_q    <= ZeroWord;
                  mul_inb_q    <= ZeroWord;
                  div_op1_q    <= ZeroWord;
                  div_op2_q    <= ZeroWord;
                  mul_signed_q <= 1'b0;
                  signed_div_q <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy          = (state_q != StIdle);
   assign mul_ina       = mul_ina_q;
   assign mul_inb       = mul_inb_q;
   assign mul_signed_o  = mul_signed_q;
   assign div_opdata1_o = div_op1_q;
   assign div_opdata2_o = div_op2_q;
   assign signed_div_o  = signed_div_q;
   assign div_start_o   = div_start_q;
   assign div_annul_o   = div_annul_q;

   hilo_reg u_hilo (
      .clk        (clk),
      .rst        (rst),
      .hi_we_i    (hi_we),
      .hi_wdata_i (hi_wdata),
      .lo_we_i    (lo_we),
      .lo_wdata_i (lo_wdata),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier (2-cycle) and divider stubs.
module tb_muldiv_ctrl;

   logic        clk, rst, flush, op_valid, ds_hold;
   logic [2:0]  op;
   logic [31:0] src1, src2;
   logic [5:0]  stall;
   logic [31:0] hi_o, lo_o, div_opdata1_o, div_opdata2_o, mul_ina, mul_inb;
   logic        stallreq_for_muldiv, busy, div_start_o, signed_div_o, div_annul_o;
   logic        div_ready_i, mul_signed_o;
   logic [63:0] div_result_i, mul_result_i, mul_prod, mul_pipe;
   logic [31:0] dq, dr;
   int          dcnt, div_lat;
   int          tests, fails;
   int          n, starts;

   muldiv_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .stall               (stall),
      .flush               (flush),
      .op_valid            (op_valid),
      .op                  (op),
      .src1                (src1),
      .src2                (src2),
      .hi_o                (hi_o),
      .lo_o                (lo_o),
      .stallreq_for_muldiv (stallreq_for_muldiv),
      .busy                (busy),
      .div_opdata1_o       (div_opdata1_o),
      .div_opdata2_o       (div_opdata2_o),
      .div_start_o         (div_start_o),
      .signed_div_o        (signed_div_o),
      .div_annul_o         (div_annul_o),
      .div_result_i        (div_result_i),
      .div_ready_i         (div_ready_i),
      .mul_ina             (mul_ina),
      .mul_inb             (mul_inb),
      .mul_signed_o        (mul_signed_o),
      .mul_result_i        (mul_result_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stall controller: EX is held whenever the block asks, or when a downstream stall is forced.
   assign stall = {3'b000, stallreq_for_muldiv | ds_hold, 2'b00};

   // Multiplier stub: one register stage, so the product is valid in the 2nd presentation cycle.
   always_comb begin
      if (mul_signed_o)
         mul_prod = $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb});
      else
         mul_prod = {32'h0, mul_ina} * {32'h0, mul_inb};
   end
   always @(posedge clk) mul_pipe <= mul_prod;
   assign mul_result_i = mul_pipe;

   // Divider stub: ready in the div_lat-th consecutive cycle of start.
   always @(posedge clk) begin
      if (!div_start_o || div_annul_o) dcnt <= 0;
      else                            dcnt <= dcnt + 1;
   end
   always_comb begin
      dq = 32'h0;
      dr = 32'h0;
      if (div_opdata2_o != 32'h0) begin
         if (signed_div_o) begin
            dq = $signed(div_opdata1_o) / $signed(div_opdata2_o);
            dr = $signed(div_opdata1_o) % $signed(div_opdata2_o);
         end else begin
            dq = div_opdata1_o / div_opdata2_o;
            dr = div_opdata1_o % div_opdata2_o;
         end
      end
   end
   assign div_result_i = {dr, dq};
   assign div_ready_i  = div_start_o && (dcnt == div_lat - 1);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an op and hold it until stallreq drops; returns stall cycles and start cycles.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int ns, output int st);
      op_valid = 1'b1;
      op       = o;
      src1     = a;
      src2     = b;
      #1;
      ns = 0;
      st = 0;
      while (stallreq_for_muldiv && ns < 100) begin
         if (div_start_o) st++;
         ns++;
         step();
      end
   endtask

   // Commit edge, after which EX advances and the instruction disappears.
   task automatic retire();
      step();
      op_valid = 1'b0;
      op       = 3'b000;
      src1     = 32'h0;
      src2     = 32'h0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0; div_lat = 33;
      rst = 1'b1; flush = 1'b0; op_valid = 1'b0; ds_hold = 1'b0;
      op = 3'b000; src1 = 32'h0; src2 = 32'h0;
      step();
      step();
      check("reset_hilo", {hi_o, lo_o}, 64'h0);
      check("reset_ctl", {busy, stallreq_for_muldiv, div_start_o, div_annul_o}, 4'b0000);
      rst = 1'b0;
      step();

      // Signed and unsigned multiply of -2 * 3.
      issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, n, starts);
      check("mult_stall_cycles", n, 3);
      check("mult_done_busy", busy, 1'b1);
      check("mult_ops_held", {mul_ina, mul_inb, 31'h0, mul_signed_o}, {64'hFFFF_FFFE_0000_0003, 32'h1});
      check("mult_no_early_commit", hi_o, 32'h0);
      retire();
      check("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
      check("mult_idle_ops_zero", {mul_ina, busy}, 33'h0);
      issue(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, n, starts);
      check("multu_stall_cycles", n, 3);
      retire();
      check("multu_hilo", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);

      // Unsigned and signed divide.
      issue(3'b011, 32'd100, 32'd7, n, starts);
      check("divu_start_cycles", starts, 33);
      check("divu_stall_cycles", n, 34);
      check("divu_done_state", {busy, div_start_o}, 2'b10);
      retire();
      check("divu_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
      issue(3'b010, 32'hFFFF_FFF9, 32'd2, n, starts);
      retire();
      check("div_signed_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

      // Divider that never answers: forced abort after 40 busy cycles.
      div_lat = 100;
      op_valid = 1'b1; op = 3'b011; src1 = 32'd9; src2 = 32'd3;
      step();
      op_valid = 1'b0;
      #1;
      n = 0;
      while (stallreq_for_muldiv && n < 100) begin
         n++;
         step();
      end
      check("timeout_busy_cycles", n, 40);
      check("timeout_annul", {div_annul_o, busy, div_start_o}, 3'b100);
      step();
      check("timeout_annul_pulse", div_annul_o, 1'b0);
      check("timeout_hilo_kept", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
      div_lat = 33;

      // mthi / mtlo on back-to-back cycles.
      op_valid = 1'b1; op = 3'b100; src1 = 32'h1234_5678;
      #1;
      check("mthi_no_stall", stallreq_for_muldiv, 1'b0);
      step();
      op = 3'b101; src1 = 32'h9ABC_DEF0;
      #1;
      check("mthi_hi", hi_o, 32'h1234_5678);
      check("mtlo_lo_not_yet", lo_o, 32'hFFFF_FFFD);
      check("mtlo_no_stall", stallreq_for_muldiv, 1'b0);
      step();
      op_valid = 1'b0; op = 3'b000; src1 = 32'h0;
      #1;
      check("mtlo_hilo", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
      check("mt_not_busy", busy, 1'b0);

      // Flush in the 10th cycle of a divide.
      op_valid = 1'b1; op = 3'b010; src1 = 32'd50; src2 = 32'd5;
      step();
      src1 = 32'hDEAD_BEEF;
      #1;
      check("div_ops_latched", {div_opdata1_o, div_opdata2_o}, {32'd50, 32'd5});
      check("div_signed_mode", {signed_div_o, div_start_o}, 2'b11);
      for (int i = 0; i < 9; i++) step();
      flush = 1'b1;
      #1;
      check("flush_cycle_stall", {stallreq_for_muldiv, div_annul_o}, 2'b10);
      step();
      flush = 1'b0; op_valid = 1'b0; op = 3'b000; src1 = 32'h0; src2 = 32'h0;
      #1;
      check("flush_annul", {div_annul_o, busy, stallreq_for_muldiv, div_start_o}, 4'b1000);
      step();
      check("flush_annul_pulse", div_annul_o, 1'b0);
      check("flush_hilo_kept", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);

      // Downstream stall while DONE: single commit on release, no restart.
      issue(3'b000, 32'h0001_0000, 32'h0001_0000, n, starts);
      ds_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("ds_hold_done", {busy, stallreq_for_muldiv}, 2'b10);
      end
      check("ds_hold_hi_kept", hi_o, 32'h1234_5678);
      ds_hold = 1'b0;
      retire();
      check("ds_commit_hilo", {hi_o, lo_o}, 64'h0000_0001_0000_0000);
      check("ds_busy_dropped", busy, 1'b0);
      step();
      check("ds_no_restart", {busy, stallreq_for_muldiv}, 2'b00);

      // Asynchronous reset in the middle of a multiply.
      op_valid = 1'b1; op = 3'b000; src1 = 32'd7; src2 = 32'd9;
      step();
      op_valid = 1'b0;
      #1;
      check("pre_reset_busy", {busy, mul_ina}, {1'b1, 32'd7});
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_hilo", {hi_o, lo_o}, 64'h0);
      check("async_rst_ops", {mul_ina, mul_inb, mul_signed_o}, 65'h0);
      check("async_rst_ctl", {busy, stallreq_for_muldiv}, 2'b00);
      step();
      rst = 1'b0;
      step();
      issue(3'b000, 32'd7, 32'd9, n, starts);
      check("post_rst_stall_cycles", n, 3);
      retire();
      check("post_rst_hilo", {hi_o, lo_o}, {32'd0, 32'd63});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences the EX-stage multi-cycle arithmetic resources: the iterative divider (`div`) and the pipelined multiplier (`mul`).
- Owns the architectural HI/LO registers and issues operands and start pulses.
- Holds the EX stage through `stallreq_for_muldiv` until a result is committed.
- Sits beside the ALU in EX. The stall controller ORs `stallreq_for_muldiv` into the existing EX stall request.

Parameters:
- `MUL_LATENCY`, 2, clock cycles from operand presentation until `mul_result_i` is valid (range 1..15).
- `DIV_TIMEOUT`, 40, maximum DIV_BUSY cycles before forced abort (safety net; ≥ divider latency + 2).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `stall`  in  `StallBus` (6)  pipeline stall vector; bit 2 = EX held
- `flush`  in  1  kill the in-flight operation (exception/branch recovery)
- `op_valid`  in  1  EX holds a mul/div/mt instruction this cycle
- `op`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others are ignored
- `src1`  in  32  rs operand
- `src2`  in  32  rt operand
- `hi_o`  out  32  HI register
- `lo_o`  out  32  LO register
- `stallreq_for_muldiv`  out  1  hold pipeline
- `busy`  out  1  state ≠ IDLE
- `div_opdata1_o`  out  32  divider operand 1
- `div_opdata2_o`  out  32  divider operand 2
- `div_start_o`  out  1  divider start
- `signed_div_o`  out  1  divider signed mode
- `div_annul_o`  out  1  divider abort
- `div_result_i`  in  64  {remainder, quotient}
- `div_ready_i`  in  1  divider result valid
- `mul_ina`  out  32  multiplier operand a
- `mul_inb`  out  32  multiplier operand b
- `mul_signed_o`  out  1  multiplier signed mode
- `mul_result_i`  in  64  product

Behaviour:
- **Reset.** On `rst` (asynchronous), all outputs and registers go to 0 and the FSM goes to IDLE. Reset mid-operation abandons the operation, and HI/LO are cleared.

- **FSM states:** IDLE, MUL_BUSY, DIV_BUSY, DONE.
  - **IDLE**
    - With `op_valid` and op mthi/mtlo: write `src1` to HI or LO at the next edge. No stall, no state change.
    - With `op_valid` and mult/multu: latch operands and signedness into internal regs, load the counter with `MUL_LATENCY`, go to MUL_BUSY.
    - With `op_valid` and div/divu: latch operands and sign, clear the timeout counter, go to DIV_BUSY.
    - `stallreq_for_muldiv` is asserted combinationally in this accept cycle.
  - **MUL_BUSY**
    - Decrement the counter each cycle.
    - When the counter reaches 1, capture `mul_result_i` into a result register and go to DONE.
    - Total stall is `MUL_LATENCY`+1 cycles.
  - **DIV_BUSY**
    - Drive `div_start_o`=1 with the latched operands until `div_ready_i`=1.
    - On `div_ready_i`: capture `div_result_i`, drop start, go to DONE.
    - On timeout: pulse `div_annul_o`, write nothing to HI/LO, go to IDLE.
  - **DONE**
    - `stallreq_for_muldiv`=0.
    - If `stall[2]`=NoStop: commit HI = result[63:32], LO = result[31:0] at this edge, then go to IDLE.
    - If `stall[2]`=Stop (a downstream stall): remain in DONE and commit exactly once when it is released.

- **Operand outputs.** Operand outputs always come from the latched registers, never from live `src1`/`src2`. They are 0 in IDLE. `mul_ina`/`mul_inb` hold steady through MUL_BUSY.

- **`stallreq_for_muldiv`** = (IDLE & `op_valid` & op is mul/div) | MUL_BUSY | DIV_BUSY.

- **Re-issue guard.** While in DONE, a still-present `op_valid` for the same instruction must not restart the operation. The DONE→IDLE transition coincides with the EX register advancing.

- **`flush`.** In any state, `flush` asserts `div_annul_o` for 1 cycle if in DIV_BUSY, discards the result, and moves the FSM to IDLE. HI/LO are unchanged. `flush` has priority over a DONE commit and over an IDLE accept.

- **Results.** Divide by zero commits whatever the divider returns, with no special case. Signedness is taken solely from `op[0]` (0 = signed).

Decomposition:
- `defines.vh` gains:
  - op encodings `MulDivOpMult`..`MulDivOpMtlo`;
  - state encodings;
  - reuse of `Stop`/`NoStop`, `DivStart`/`DivStop`, `DivResultReady`/`DivResultNotReady`, and `ZeroWord`.
- One natural sub-module: `hilo_reg` (HI/LO storage with independent write enables and async reset). The FSM stays in `muldiv_ctrl`.

Test Plan:
1. Multiply: mult, `src1`=0xFFFFFFFE (−2), `src2`=3, `MUL_LATENCY`=2, multiplier model returns the product after 2 cycles.
   → stall for 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
2. Divide: divu, `src1`=100, `src2`=7, divider model returns ready after 33 cycles.
   → `div_start_o` high for 33 cycles, stall deasserts in DONE, then HI=2, LO=14. Signed div −7/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
3. Move to HI/LO: mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles.
   → no stall, `hi_o`/`lo_o` updated one edge after each.
4. Flush mid-divide: issue a div, assert `flush` at cycle 10.
   → `div_annul_o` pulses once, FSM returns to IDLE, HI/LO retain their prior values, stall drops the next cycle.
5. Downstream stall at DONE: hold `stall[2]`=Stop for 4 cycles after mult reaches DONE.
   → HI/LO commit once on release, no second multiply started, `busy` drops the cycle after the commit.
6. Async reset mid-operation: assert `rst` between edges during MUL_BUSY.
   → all outputs are 0 immediately (before the next edge) and the FSM is in IDLE; a mult issued after deassertion completes normally.
